// File: rtl/hist_bar_render.sv
// hist_bar_render: per-frame 256-bin gray histogram, rendered from the previous frame as an auto-scaled bottom-aligned bar graph
// Ports: iClk pixel clock; iRst_n async active-low reset; iFval frame valid; iGray/iGray_Valid pixel and qualifier
//        (iGray_Valid also qualifies display timing); iX_Cont/iY_Cont pixel position; iThresholdLevel marked bin;
//        oHist bar pixel (255 bar, 0 background); oHist_Valid qualifier; oHist_Red marked-bin column; oOverrun late-frame pulse
// Option: define HIST_GRID_EN to draw gray (128) background grid lines every 32 bins
module hist_bar_render #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BIN_W = 19
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iFval,
  input  logic [7:0]  iGray,
  input  logic        iGray_Valid,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic [7:0]  iThresholdLevel,
  output logic [7:0]  oHist,
  output logic        oHist_Valid,
  output logic        oHist_Red,
  output logic        oOverrun
);
  localparam int SW = $clog2(BIN_W + 1);
  localparam logic [2:0] INIT = 3'd0, WAIT_SOF = 3'd1, ACCUM = 3'd2, PEAK_CLR = 3'd3, SHIFT = 3'd4, SWAP = 3'd5;
  logic [2:0] state;
  logic [7:0] addr;
  logic [BIN_W-1:0] peak;
  logic [SW-1:0] s, shift;
  logic accBank, dispOk, fvalD;
  logic [BIN_W-1:0] bank [2][256];
  logic rise, fall, take;
  logic v1, wrV;
  logic [7:0] g1, wrA;
  logic [BIN_W-1:0] wrD, base, incd, scanVal, h;
  logic dv, dIn, dRed, bar;
  logic [7:0] dBin, bg;
  logic [15:0] dY;
  assign rise = iFval & ~fvalD;
  assign fall = ~iFval & fvalD;
  // a pixel arriving on the very start-of-frame cycle still belongs to the frame
  assign take = iGray_Valid & (state == ACCUM || (state == WAIT_SOF && rise));
  // the only in-flight update not yet in memory is the one in the write stage
  assign base = (wrV && wrA == g1) ? wrD : bank[accBank][g1];
  assign incd = &base ? base : base + BIN_W'(1);
  // the peak scan can overlap the last two increments draining out of the pipeline
  assign scanVal = (v1 && g1 == addr) ? incd : (wrV && wrA == addr) ? wrD : bank[accBank][addr];
  assign h = bank[~accBank][dBin] >> shift;
  assign bar = dIn & dispOk & (32'(dY) + 32'(h) >= 32'(V_ACTIVE));
`ifdef HIST_GRID_EN
  assign bg = (dIn && dBin[4:0] == 5'd0) ? 8'd128 : 8'd0;
`else
  assign bg = 8'd0;
`endif
  always_ff @(posedge iClk) begin
    if (state == INIT) begin
      bank[0][addr] <= '0;
      bank[1][addr] <= '0;
    end else begin
      if (wrV) bank[accBank][wrA] <= wrD;
      if (state == PEAK_CLR) bank[~accBank][addr] <= '0;
    end
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= INIT;
      addr <= '0;
      peak <= '0;
      s <= '0;
      shift <= '0;
      accBank <= 1'b0;
      dispOk <= 1'b0;
      fvalD <= 1'b0;
      oOverrun <= 1'b0;
      v1 <= 1'b0;
      g1 <= '0;
      wrV <= 1'b0;
      wrA <= '0;
      wrD <= '0;
    end else begin
      fvalD <= iFval;
      v1 <= take;
      g1 <= iGray;
      wrV <= v1;
      wrA <= g1;
      wrD <= incd;
      oOverrun <= rise & (state == PEAK_CLR || state == SHIFT || state == SWAP);
      addr <= (state == INIT || state == PEAK_CLR) ? addr + 8'd1 : 8'd0;
      case (state)
        INIT: if (&addr) state <= WAIT_SOF;
        WAIT_SOF: if (rise) state <= ACCUM;
        ACCUM: if (fall) begin
          state <= PEAK_CLR;
          peak <= '0;
        end
        PEAK_CLR: begin
          peak <= scanVal > peak ? scanVal : peak;
          if (&addr) begin
            state <= SHIFT;
            s <= '0;
          end
        end
        SHIFT: if ((peak >> s) > BIN_W'(V_ACTIVE - 1) && s < SW'(BIN_W)) s <= s + SW'(1);
          else state <= SWAP;
        SWAP: begin
          accBank <= ~accBank;
          shift <= s;
          dispOk <= 1'b1;
          state <= WAIT_SOF;
        end
        default: state <= INIT;
      endcase
    end
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dv <= 1'b0;
      dIn <= 1'b0;
      dRed <= 1'b0;
      dBin <= '0;
      dY <= '0;
      oHist <= '0;
      oHist_Valid <= 1'b0;
      oHist_Red <= 1'b0;
    end else begin
      dv <= iGray_Valid;
      dIn <= iX_Cont < 16'd512 && iX_Cont < 16'(H_ACTIVE);
      dRed <= iX_Cont < 16'd512 && iX_Cont < 16'(H_ACTIVE) && iX_Cont[8:1] == iThresholdLevel;
      dBin <= iX_Cont[8:1];
      dY <= iY_Cont;
      oHist_Valid <= dv;
      oHist <= !dv ? 8'd0 : bar ? 8'd255 : bg;
      oHist_Red <= dv & dRed;
    end
  end
endmodule
